// File: rtl/fb_write_arbiter_if.sv
// Pixel-write bus shared by the drawing requesters, the clear command and the framebuffer port.
// Handshake: a transfer happens in any cycle where reqN_valid && reqN_ready are both high.
interface fb_write_arbiter_if #(
    parameter int XW = 11,
    parameter int YW = 11
);
    logic          req0_valid;
    logic [XW-1:0] req0_x;
    logic [YW-1:0] req0_y;
    logic          req0_color;
    logic          req0_ready;

    logic          req1_valid;
    logic [XW-1:0] req1_x;
    logic [YW-1:0] req1_y;
    logic          req1_color;
    logic          req1_ready;

    logic          clear_start;
    logic          clear_color;
    logic          clear_busy;
    logic          clear_done;

    logic [XW-1:0] fb_x;
    logic [YW-1:0] fb_y;
    logic          fb_color;
    logic          fb_write;

    modport master (
        output req0_valid, req0_x, req0_y, req0_color,
        output req1_valid, req1_x, req1_y, req1_color,
        output clear_start, clear_color,
        input  req0_ready, req1_ready, clear_busy, clear_done,
        input  fb_x, fb_y, fb_color, fb_write
    );

    modport slave (
        input  req0_valid, req0_x, req0_y, req0_color,
        input  req1_valid, req1_x, req1_y, req1_color,
        input  clear_start, clear_color,
        output req0_ready, req1_ready, clear_busy, clear_done,
        output fb_x, fb_y, fb_color, fb_write
    );
endinterface

// File: rtl/fb_write_arbiter.sv
// Round-robin arbiter for the framebuffer pixel-write port with a built-in
// row-major full-screen clear engine; all framebuffer-facing outputs are registered.
module fb_write_arbiter #(
    parameter int XW   = 11,
    parameter int YW   = 11,
    parameter int XMAX = 640,
    parameter int YMAX = 480
) (
    input  logic                clk,
    input  logic                reset,
    fb_write_arbiter_if.slave   bus,
    output logic                dbg_state
);
    typedef enum logic {
        ARB   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [XW-1:0] X_LAST = XW'(XMAX - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(YMAX - 1);

    state_t        state;
    state_t        state_next;
    logic          last_grant;
    logic          grant0;
    logic          grant1;
    logic          clr_color;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic          sweep_last;

    assign sweep_last = (cx == X_LAST) && (cy == Y_LAST);

    // Grants are combinational on current valids; a tie goes to whoever did not win last.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state;
        case (state)
            ARB: begin
                if (!reset) begin
                    if (bus.req0_valid && bus.req1_valid) begin
                        if (last_grant) grant0 = 1'b1;
                        else            grant1 = 1'b1;
                    end else if (bus.req0_valid) begin
                        grant0 = 1'b1;
                    end else if (bus.req1_valid) begin
                        grant1 = 1'b1;
                    end
                end
                if (bus.clear_start) state_next = CLEAR;
            end
            CLEAR: begin
                if (sweep_last) state_next = ARB;
            end
            default: state_next = ARB;
        endcase
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.clear_busy = (state == CLEAR);
    assign dbg_state      = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ARB;
            last_grant     <= 1'b1;
            clr_color      <= 1'b0;
            cx             <= '0;
            cy             <= '0;
            bus.fb_x       <= '0;
            bus.fb_y       <= '0;
            bus.fb_color   <= 1'b0;
            bus.fb_write   <= 1'b0;
            bus.clear_done <= 1'b0;
        end else begin
            state          <= state_next;
            bus.fb_write   <= 1'b0;
            bus.clear_done <= 1'b0;
            case (state)
                ARB: begin
                    if (grant0) begin
                        bus.fb_x     <= bus.req0_x;
                        bus.fb_y     <= bus.req0_y;
                        bus.fb_color <= bus.req0_color;
                        bus.fb_write <= 1'b1;
                        last_grant   <= 1'b0;
                    end else if (grant1) begin
                        bus.fb_x     <= bus.req1_x;
                        bus.fb_y     <= bus.req1_y;
                        bus.fb_color <= bus.req1_color;
                        bus.fb_write <= 1'b1;
                        last_grant   <= 1'b1;
                    end
                    // The color is captured here so later changes cannot disturb a running sweep.
                    if (bus.clear_start) begin
                        clr_color <= bus.clear_color;
                        cx        <= '0;
                        cy        <= '0;
                    end
                end
                CLEAR: begin
                    bus.fb_x     <= cx;
                    bus.fb_y     <= cy;
                    bus.fb_color <= clr_color;
                    bus.fb_write <= 1'b1;
                    if (sweep_last) begin
                        bus.clear_done <= 1'b1;
                        cx             <= '0;
                        cy             <= '0;
                    end else if (cx == X_LAST) begin
                        cx <= '0;
                        cy <= cy + 1'b1;
                    end else begin
                        cx <= cx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter on a 4x3 screen: reset, single writes,
// round-robin contention, clear sweeps with competing requests.
module tb_fb_write_arbiter;
    localparam int XW   = 11;
    localparam int YW   = 11;
    localparam int XMAX = 4;
    localparam int YMAX = 3;

    logic clk;
    logic reset;
    logic dbg_state;
    int   errors;
    int   checks;

    fb_write_arbiter_if #(.XW(XW), .YW(YW)) bus ();

    fb_write_arbiter #(.XW(XW), .YW(YW), .XMAX(XMAX), .YMAX(YMAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req0(input logic v, input int x, input int y, input logic c);
        bus.req0_valid = v;
        bus.req0_x     = XW'(x);
        bus.req0_y     = YW'(y);
        bus.req0_color = c;
    endtask

    task automatic set_req1(input logic v, input int x, input int y, input logic c);
        bus.req1_valid = v;
        bus.req1_x     = XW'(x);
        bus.req1_y     = YW'(y);
        bus.req1_color = c;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        set_req0(1'b0, 0, 0, 1'b0);
        set_req1(1'b0, 0, 0, 1'b0);
        bus.clear_start = 1'b0;
        bus.clear_color = 1'b0;

        // Reset state, with a request pending to show readys stay low.
        step();
        step();
        set_req0(1'b1, 3, 3, 1'b1);
        #1;
        check("rst_ready0", bus.req0_ready, 1'b0);
        step();
        check("rst_fb_write", bus.fb_write, 1'b0);
        check("rst_fb_x", bus.fb_x, 0);
        check("rst_fb_y", bus.fb_y, 0);
        check("rst_fb_color", bus.fb_color, 1'b0);
        check("rst_busy", bus.clear_busy, 1'b0);
        check("rst_done", bus.clear_done, 1'b0);
        check("rst_state", dbg_state, 1'b0);
        set_req0(1'b0, 0, 0, 1'b0);
        reset = 1'b0;

        // Idle: nothing written for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_fb_write", bus.fb_write, 1'b0);
            check("idle_fb_x", bus.fb_x, 0);
        end

        // Single request from requester 0.
        set_req0(1'b1, 5, 7, 1'b1);
        #1;
        check("single_ready0", bus.req0_ready, 1'b1);
        check("single_ready1", bus.req1_ready, 1'b0);
        step();
        set_req0(1'b0, 0, 0, 1'b0);
        check("single_fb_x", bus.fb_x, 5);
        check("single_fb_y", bus.fb_y, 7);
        check("single_fb_color", bus.fb_color, 1'b1);
        check("single_fb_write", bus.fb_write, 1'b1);
        step();
        check("hold_fb_write", bus.fb_write, 1'b0);
        check("hold_fb_x", bus.fb_x, 5);
        check("hold_fb_y", bus.fb_y, 7);

        // Reset mid-stream.
        set_req0(1'b1, 6, 2, 1'b0);
        step();
        check("stream_fb_write", bus.fb_write, 1'b1);
        check("stream_fb_x", bus.fb_x, 6);
        reset = 1'b1;
        #1;
        check("midrst_ready0", bus.req0_ready, 1'b0);
        step();
        check("midrst_fb_write", bus.fb_write, 1'b0);
        check("midrst_busy", bus.clear_busy, 1'b0);
        check("midrst_fb_x", bus.fb_x, 0);
        reset = 1'b0;

        // Contention: grants alternate 0,1,0,1 starting with requester 0.
        set_req0(1'b1, 1, 1, 1'b0);
        set_req1(1'b1, 2, 2, 1'b1);
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rr_ready0", bus.req0_ready, (i % 2) == 0);
            check("rr_ready1", bus.req1_ready, (i % 2) == 1);
            step();
            check("rr_fb_write", bus.fb_write, 1'b1);
            check("rr_fb_x", bus.fb_x, ((i % 2) == 0) ? 1 : 2);
            check("rr_fb_color", bus.fb_color, (i % 2) == 1);
        end
        set_req0(1'b0, 0, 0, 1'b0);
        set_req1(1'b0, 0, 0, 1'b0);
        step();
        check("rr_idle_write", bus.fb_write, 1'b0);

        // Clear pulse alongside a req0 grant; req1 then waits through the sweep.
        set_req0(1'b1, 5, 7, 1'b1);
        bus.clear_start = 1'b1;
        bus.clear_color = 1'b1;
        #1;
        check("clr_t_ready0", bus.req0_ready, 1'b1);
        check("clr_t_busy", bus.clear_busy, 1'b0);
        step();
        bus.clear_start = 1'b0;
        bus.clear_color = 1'b0;
        set_req0(1'b0, 0, 0, 1'b0);
        set_req1(1'b1, 9, 4, 1'b0);
        #1;
        check("clr_t1_fb_x", bus.fb_x, 5);
        check("clr_t1_fb_y", bus.fb_y, 7);
        check("clr_t1_fb_write", bus.fb_write, 1'b1);
        check("clr_t1_busy", bus.clear_busy, 1'b1);
        check("clr_t1_done", bus.clear_done, 1'b0);
        check("clr_t1_ready1", bus.req1_ready, 1'b0);
        check("clr_t1_state", dbg_state, 1'b1);
        for (int k = 0; k < XMAX * YMAX; k++) begin
            step();
            bus.clear_start = (k == 1);
            #1;
            check("sweep_fb_x", bus.fb_x, k % XMAX);
            check("sweep_fb_y", bus.fb_y, k / XMAX);
            check("sweep_fb_color", bus.fb_color, 1'b1);
            check("sweep_fb_write", bus.fb_write, 1'b1);
            check("sweep_done", bus.clear_done, k == XMAX * YMAX - 1);
            check("sweep_busy", bus.clear_busy, k != XMAX * YMAX - 1);
            check("sweep_ready1", bus.req1_ready, k == XMAX * YMAX - 1);
        end
        step();
        set_req1(1'b0, 0, 0, 1'b0);
        check("post_fb_x", bus.fb_x, 9);
        check("post_fb_y", bus.fb_y, 4);
        check("post_fb_color", bus.fb_color, 1'b0);
        check("post_fb_write", bus.fb_write, 1'b1);
        check("post_done", bus.clear_done, 1'b0);
        step();
        check("post_idle_write", bus.fb_write, 1'b0);
        check("post_idle_busy", bus.clear_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Shares the single pixel-write port of the VGA framebuffer between two drawing requesters (for example the board/line drawer and a cursor or status overlay) and an internal full-screen clear engine. Sits between the screen-level drawing logic and the framebuffer: it accepts pixel writes through valid/ready handshakes, arbitrates round-robin between the requesters, and sequences a row-major clear sweep on command. All framebuffer-facing outputs are registered.

## Interface
Parameters:
- XW, 11, width of x coordinate
- YW, 11, width of y coordinate
- XMAX, 640, horizontal pixel count swept by clear (x runs 0..XMAX-1)
- YMAX, 480, vertical pixel count swept by clear (y runs 0..YMAX-1)

Ports:
- clk  in  1  system clock; one clock domain, all logic on posedge
- reset  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has a pixel to write
- req0_x  in  XW  requester 0 x coordinate
- req0_y  in  YW  requester 0 y coordinate
- req0_color  in  1  requester 0 pixel color
- req0_ready  out  1  requester 0 transfer accepted this cycle (combinational)
- req1_valid, req1_x, req1_y, req1_color, req1_ready  same as requester 0
- clear_start  in  1  single-cycle pulse: begin clear sweep
- clear_color  in  1  color written by the clear sweep; sampled with clear_start
- clear_busy  out  1  clear sweep in progress
- clear_done  out  1  one-cycle pulse when the last clear pixel is presented
- fb_x  out  XW  framebuffer x
- fb_y  out  YW  framebuffer y
- fb_color  out  1  framebuffer pixel color
- fb_write  out  1  framebuffer write strobe, one pixel per asserted cycle

## Operation
- States: ARB, CLEAR.
- Reset: state ARB; fb_x=0, fb_y=0, fb_color=0, fb_write=0; clear_busy=0, clear_done=0; req0_ready=req1_ready=0; clear counters 0; last_grant=1 (requester 0 wins first tie).
- ARB, grant rule (combinational on current inputs):
  - only reqN_valid high -> reqN_ready=1.
  - both high -> grant the requester not in last_grant.
  - neither -> no ready.
  - at most one ready high in any cycle.
- Transfer occurs when reqN_valid && reqN_ready; last_grant <= N; next cycle fb_* carry that requester's x/y/color with fb_write=1.
- Requesters hold x/y/color stable while valid and not ready; valid is not withdrawn before ready.
- No transfer in a cycle -> fb_write=0 next cycle; fb_x/fb_y/fb_color hold their last values.
- ARB with clear_start=1: state <= CLEAR, latch clear_color, counters cx=0, cy=0. A request granted in that same cycle still completes.
- CLEAR:
  - both readys forced 0; clear_busy=1.
  - each cycle emit (cx, cy, latched color) to fb_* registers with fb_write=1.
  - advance row-major: cx+1; at cx=XMAX-1, cx<=0 and cy+1.
  - after emitting (XMAX-1, YMAX-1), state <= ARB.
- clear_start while in CLEAR is ignored; clear_color changes during CLEAR have no effect.
- Reset asserted mid-sweep aborts the clear immediately; all outputs take reset values on the next edge.
- Counter widths are XW/YW; XMAX-1 and YMAX-1 must be representable.

## Timing
- Requester latency: transfer in cycle t -> fb_write=1 with its data in cycle t+1. Sustained throughput is 1 pixel/cycle across both requesters.
- Clear latency:
  - clear_start high in cycle t -> clear_busy=1 from t+1.
  - first pixel (0,0) on fb_* in cycle t+2.
  - last pixel (XMAX-1,YMAX-1) on fb_* in cycle t+1+XMAX*YMAX, with clear_done=1 that same cycle.
  - clear_busy=0 in that cycle and after.
- Readys may first reassert in cycle t+1+XMAX*YMAX.
- fb_write is continuous during a sweep with no gaps. Total writes per sweep = XMAX*YMAX.

## Test plan
- Reset, then idle: all outputs 0 and no fb_write for 10 cycles. Assert reset mid-stream -> next cycle fb_write=0, clear_busy=0.
- Single request: req0 valid with (5,7,1) in cycle t -> req0_ready=1 in t; fb_x=5, fb_y=7, fb_color=1, fb_write=1 in t+1.
- Contention: both valid continuously, req0=(1,1), req1=(2,2) -> grants alternate 0,1,0,1 starting with 0 after reset. The fb_x sequence is 1,2,1,2 with no idle cycle.
- Clear sweep, XMAX=4, YMAX=3, clear_color=1, pulse at t -> 12 consecutive writes (0,0),(1,0),(2,0),(3,0),(0,1),…,(3,2) in cycles t+2..t+13. clear_done pulses only at t+13; clear_busy is high t+1..t+12.
- Clear with contention: req1 valid throughout the sweep -> req1_ready=0 while clear_busy. req1 is granted in cycle t+13, and its pixel appears at t+14.
- Simultaneous clear_start and req0 grant in t -> req0 pixel at t+1, clear pixel (0,0) at t+2. A second clear_start during the sweep does not restart it (still exactly 12 writes).
